// File: rtl/seq_divider_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package div_pkg;

  localparam int DVD_W_DEF = 8;
  localparam int DVS_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle between a producer/consumer and seq_divider.
interface seq_divider_if
  import div_pkg::*;
#(
  parameter int DVD_W = DVD_W_DEF,
  parameter int DVS_W = DVS_W_DEF
) ();

  logic             start;
  logic             in_ready;
  logic [DVD_W-1:0] dividend;
  logic [DVS_W-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [DVD_W-1:0] quotient;
  logic [DVS_W-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step
  import div_pkg::*;
#(
  parameter int DVS_W = DVS_W_DEF
) (
  input  logic [DVS_W:0]   rem_in,
  input  logic [DVS_W-1:0] divisor,
  input  logic             bit_in,
  output logic [DVS_W:0]   rem_out,
  output logic             q_bit
);

  logic [DVS_W+1:0] shifted;

  assign shifted = {rem_in, bit_in};
  // Full-width compare keeps divide-by-zero well defined when rem_in's top bit is set.
  assign q_bit   = (shifted >= {2'b00, divisor});
  assign rem_out = q_bit ? (shifted[DVS_W:0] - {1'b0, divisor}) : shifted[DVS_W:0];

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, MSB first.
// Build option: SEQ_DIVIDER_ZERO_FAST_EN skips the iterations for a zero divisor.
//
// state | meaning
// IDLE  | waiting for start, in_ready high
// RUN   | iterating, down-counter cnt reaches 0 on the last step
// DONE  | result presented, held until out_ready
module seq_divider
  import div_pkg::*;
#(
  parameter int DVD_W = DVD_W_DEF,
  parameter int DVS_W = DVS_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_divider_if.slave bus
);

  localparam int CNT_W = $clog2(DVD_W + 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [DVD_W-1:0] quo_q;
  logic [DVS_W:0]   rem_q;
  logic [DVS_W-1:0] dvs_q;
  logic             dbz_q;
  logic [DVS_W:0]   rem_step;
  logic             q_bit;
  logic             accept;
  logic             last;
  logic             valid;

  assign accept = (state == IDLE) && bus.start;

`ifdef SEQ_DIVIDER_ZERO_FAST_EN
  assign last = (cnt == '0) || dbz_q;
`else
  assign last = (cnt == '0);
`endif

  // quo_q starts as the dividend; its MSB feeds the step while quotient bits shift in at the LSB.
  div_step #(.DVS_W(DVS_W)) u_step (
    .rem_in  (rem_q),
    .divisor (dvs_q),
    .bit_in  (quo_q[DVD_W-1]),
    .rem_out (rem_step),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start)     state_nxt = RUN;
      RUN:  if (last)          state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      dbz_q <= 1'b0;
    end else if (accept) begin
      cnt   <= CNT_W'(DVD_W - 1);
      quo_q <= bus.dividend;
      rem_q <= '0;
      dvs_q <= bus.divisor;
      dbz_q <= (bus.divisor == '0);
    end else if (state == RUN) begin
`ifdef SEQ_DIVIDER_ZERO_FAST_EN
      if (dbz_q) begin
        quo_q <= '1;
        rem_q <= {1'b0, quo_q[DVS_W-1:0]};
      end else begin
        quo_q <= {quo_q[DVD_W-2:0], q_bit};
        rem_q <= rem_step;
        cnt   <= cnt - CNT_W'(1);
      end
`else
      quo_q <= {quo_q[DVD_W-2:0], q_bit};
      rem_q <= rem_step;
      cnt   <= cnt - CNT_W'(1);
`endif
    end
  end

  // Results are gated so they read as zero whenever out_valid is low.
  assign valid           = (state == DONE);
  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = valid;
  assign bus.quotient    = valid ? quo_q : '0;
  assign bus.remainder   = valid ? rem_q[DVS_W-1:0] : '0;
  assign bus.div_by_zero = valid & dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider against an arithmetic reference model.
module tb_seq_divider;

  localparam int DVD_W = 8;
  localparam int DVS_W = 4;
`ifdef SEQ_DIVIDER_ZERO_FAST_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = DVD_W;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_divider_if #(.DVD_W(DVD_W), .DVS_W(DVS_W)) bus ();

  seq_divider #(.DVD_W(DVD_W), .DVS_W(DVS_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic void model(input int a, input int b,
                                output int q, output int r, output int z, output int lat);
    if (b == 0) begin
      q   = (1 << DVD_W) - 1;
      r   = a % (1 << DVS_W);
      z   = 1;
      lat = ZERO_LAT;
    end else begin
      q   = a / b;
      r   = a % b;
      z   = 0;
      lat = DVD_W;
    end
  endfunction

  // Drives one operation, waits for the result, captures it and consumes it.
  task automatic run_op(input int a, input int b,
                        output logic [DVD_W-1:0] q, output logic [DVS_W-1:0] r,
                        output logic z, output int lat);
    int guard;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    bus.start    = 1'b1;
    bus.dividend = a[DVD_W-1:0];
    bus.divisor  = b[DVS_W-1:0];
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    q = bus.quotient;
    r = bus.remainder;
    z = bus.div_by_zero;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.quotient !== '0 ||
        bus.remainder !== '0 || bus.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset: got rdy=%b vld=%b q=%h r=%h z=%b, expected rdy=1 vld=0 q=0 r=0 z=0",
               bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    int da[5] = '{200, 255, 9, 165, 100};
    int db[5] = '{7, 1, 15, 0, 3};
    logic [DVD_W-1:0] q;
    logic [DVS_W-1:0] r;
    logic z;
    int lat, eq, er, ez, el;
    for (int i = 0; i < 5; i++) begin
      model(da[i], db[i], eq, er, ez, el);
      run_op(da[i], db[i], q, r, z, lat);
      checks++;
      if (q !== eq[DVD_W-1:0] || r !== er[DVS_W-1:0] || z !== ez[0]) begin
        errors++;
        $display("FAIL directed %0d/%0d: got q=%0d r=%0d z=%b, expected q=%0d r=%0d z=%0d",
                 da[i], db[i], q, r, z, eq, er, ez);
      end
      checks++;
      if (lat !== el) begin
        errors++;
        $display("FAIL directed_latency %0d/%0d: got %0d, expected %0d", da[i], db[i], lat, el);
      end
      checks++;
      if (bus.out_valid !== 1'b0 || bus.quotient !== '0 || bus.remainder !== '0 ||
          bus.div_by_zero !== 1'b0) begin
        errors++;
        $display("FAIL directed_idle_zero: got vld=%b q=%h r=%h z=%b, expected all 0",
                 bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero);
      end
    end
  endtask

  task automatic test_hold_and_ignore();
    int lat;
    logic [DVD_W-1:0] q;
    logic [DVS_W-1:0] r;
    logic z;
    bus.start    = 1'b1;
    bus.dividend = 8'd50;
    bus.divisor  = 4'd3;
    @(negedge clk);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      bus.dividend = DVD_W'($urandom);
      bus.divisor  = DVS_W'($urandom);
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== DVD_W || bus.quotient !== 8'd16 || bus.remainder !== 4'd2 || bus.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL start_in_run: got lat=%0d q=%0d r=%0d z=%b, expected lat=%0d q=16 r=2 z=0",
               lat, bus.quotient, bus.remainder, bus.div_by_zero, DVD_W);
    end
    for (int i = 0; i < 5; i++) begin
      bus.start    = 1'($urandom);
      bus.dividend = DVD_W'($urandom);
      bus.divisor  = DVS_W'($urandom);
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.quotient !== 8'd16 ||
          bus.remainder !== 4'd2 || bus.div_by_zero !== 1'b0) begin
        errors++;
        $display("FAIL done_hold cycle %0d: got vld=%b rdy=%b q=%0d r=%0d z=%b, expected vld=1 rdy=0 q=16 r=2 z=0",
                 i, bus.out_valid, bus.in_ready, bus.quotient, bus.remainder, bus.div_by_zero);
      end
    end
    // start held high across the release edge must only be taken on the edge after it
    bus.start     = 1'b1;
    bus.dividend  = 8'd100;
    bus.divisor   = 4'd3;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.quotient !== '0 ||
        bus.remainder !== '0 || bus.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL release_edge: got rdy=%b vld=%b q=%h r=%h z=%b, expected rdy=1 vld=0 outputs 0",
               bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    q = bus.quotient;
    r = bus.remainder;
    z = bus.div_by_zero;
    checks++;
    if (lat !== DVD_W || q !== 8'd33 || r !== 4'd1 || z !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back 100/3: got lat=%0d q=%0d r=%0d z=%b, expected lat=%0d q=33 r=1 z=0",
               lat, q, r, z, DVD_W);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [DVD_W-1:0] q;
    logic [DVS_W-1:0] r;
    logic z;
    int lat, guard;
    bit seen;
    bus.start    = 1'b1;
    bus.dividend = 8'd77;
    bus.divisor  = 4'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.quotient !== '0 ||
        bus.remainder !== '0 || bus.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run: got rdy=%b vld=%b q=%h r=%h z=%b, expected rdy=1 vld=0 outputs 0",
               bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(100, 3, q, r, z, lat);
    checks++;
    if (lat !== DVD_W || q !== 8'd33 || r !== 4'd1 || z !== 1'b0) begin
      errors++;
      $display("FAIL after_reset 100/3: got lat=%0d q=%0d r=%0d z=%b, expected lat=%0d q=33 r=1 z=0",
               lat, q, r, z, DVD_W);
    end
    // reset while a result is waiting in DONE
    bus.start    = 1'b1;
    bus.dividend = 8'd165;
    bus.divisor  = 4'd0;
    @(negedge clk);
    bus.start = 1'b0;
    guard = 0;
    while (bus.out_valid !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.quotient !== '0 || bus.remainder !== '0 ||
        bus.div_by_zero !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_done: got rdy=%b vld=%b q=%h r=%h z=%b, expected rdy=1 vld=0 outputs 0",
               bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abandoned_op: got spurious activity after reset release, expected idle");
    end
  endtask

  task automatic test_random();
    logic [DVD_W-1:0] q;
    logic [DVS_W-1:0] r;
    logic z;
    int a, b, lat, eq, er, ez, el;
    for (int i = 0; i < 200; i++) begin
      a = int'($urandom_range(0, (1 << DVD_W) - 1));
      b = int'($urandom_range(0, (1 << DVS_W) - 1));
      model(a, b, eq, er, ez, el);
      run_op(a, b, q, r, z, lat);
      checks++;
      if (q !== eq[DVD_W-1:0] || r !== er[DVS_W-1:0] || z !== ez[0] || lat !== el) begin
        errors++;
        $display("FAIL random %0d/%0d: got q=%0d r=%0d z=%b lat=%0d, expected q=%0d r=%0d z=%0d lat=%0d",
                 a, b, q, r, z, lat, eq, er, ez, el);
      end
    end
  endtask

  task automatic test_exhaustive();
    logic [DVD_W-1:0] q;
    logic [DVS_W-1:0] r;
    logic z;
    int lat, eq, er, ez, el;
    for (int a = 0; a < (1 << DVD_W); a++) begin
      for (int b = 0; b < (1 << DVS_W); b++) begin
        model(a, b, eq, er, ez, el);
        run_op(a, b, q, r, z, lat);
        checks++;
        if (q !== eq[DVD_W-1:0] || r !== er[DVS_W-1:0] || z !== ez[0] || lat !== el) begin
          errors++;
          $display("FAIL exhaustive %0d/%0d: got q=%0d r=%0d z=%b lat=%0d, expected q=%0d r=%0d z=%0d lat=%0d",
                   a, b, q, r, z, lat, eq, er, ez, el);
        end
      end
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    test_reset();
    test_directed();
    test_hold_and_ignore();
    test_reset_mid_run();
    test_random();
    test_exhaustive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter DVD_W, default 8, dividend and quotient width.
REQ-002 SHALL have parameter DVS_W, default 4, divisor and remainder width; DVS_W <= DVD_W.
REQ-003 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1, operand valid.
REQ-006 SHALL have port in_ready, output, 1, high only in IDLE.
REQ-007 SHALL have port dividend, input, DVD_W, unsigned dividend.
REQ-008 SHALL have port divisor, input, DVS_W, unsigned divisor.
REQ-009 SHALL have port out_valid, output, 1, result valid.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-011 SHALL have port quotient, output, DVD_W, unsigned quotient.
REQ-012 SHALL have port remainder, output, DVS_W, unsigned remainder.
REQ-013 SHALL have port div_by_zero, output, 1, divisor was 0; valid with out_valid.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 SHALL accept an operation on a rising edge with start=1 and in_ready=1, registering both operands and entering RUN.
REQ-016 SHALL ignore start while in RUN or DONE; operand inputs are don't-care there.
REQ-017 SHALL use restoring division: shift 1 dividend bit into a DVS_W+1 partial remainder, trial-subtract divisor, keep if non-negative, shift result bit into quotient, MSB first.
REQ-018 SHALL remain in RUN exactly DVD_W cycles; out_valid rises on the edge DVD_W cycles after acceptance.
REQ-019 SHALL in DONE hold quotient, remainder, div_by_zero, out_valid stable until out_ready=1 is sampled.
REQ-020 SHALL transition DONE->IDLE on the edge with out_ready=1; out_valid drops on that edge.
REQ-021 SHALL NOT accept a new start on the same edge as DONE->IDLE; earliest acceptance is the following edge.
REQ-022 SHALL for nonzero divisor produce dividend = quotient*divisor + remainder, remainder < divisor.
REQ-023 SHALL for divisor=0 set div_by_zero=1, quotient all ones, remainder = dividend[DVS_W-1:0].
REQ-024 SHALL hold quotient, remainder and div_by_zero at 0 whenever out_valid=0.

Reset
REQ-025 SHALL on rst_n=0 immediately force state IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0.
REQ-026 SHALL abandon any RUN/DONE operation on reset with no output produced after release.
REQ-027 SHALL accept start on the first rising edge after rst_n deasserts.

Configuration
REQ-028 SHALL, with macro SEQ_DIVIDER_ZERO_FAST_EN defined, go from acceptance of divisor=0 directly to DONE, out_valid one cycle after acceptance.
REQ-029 SHALL, without SEQ_DIVIDER_ZERO_FAST_EN, spend the full DVD_W RUN cycles on divisor=0; outputs per REQ-023 in both cases.

Structure
REQ-030 SHALL take the state enum and default DVD_W/DVS_W constants from shared package div_pkg.
REQ-031 SHALL implement one iteration in combinational sub-module div_step (partial remainder, divisor, next bit -> next remainder, quotient bit).

Verification
REQ-032 SHALL test 200/7: quotient=28, remainder=4, div_by_zero=0, out_valid 8 cycles after accept.
REQ-033 SHALL test 255/1 -> 255 r0 and 9/15 -> 0 r9.
REQ-034 SHALL test 0xA5/0: div_by_zero=1, quotient=0xFF, remainder=5; latency 1 with SEQ_DIVIDER_ZERO_FAST_EN, 8 without.
REQ-035 SHALL test out_ready low 5 cycles in DONE: outputs stable; start pulses during RUN/DONE ignored.
REQ-036 SHALL test rst_n low mid-RUN (cycle 4): outputs 0 at once, in_ready=1, next 100/3 -> 33 r1.
REQ-037 SHALL compare all 2^12 operand pairs against a reference model.
